// File: rtl/pin_group_router.sv
// pin_group_router: routes one group of core pins to one of several pad groups with glitch-free break-before-make switchover
module pin_group_router #(
    parameter int PINS            = 8,
    parameter int ROUTES          = 2,
    parameter int SEL_W           = 3,
    parameter int RESET_ROUTE     = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int GUARD_CYCLES    = 16
) (
    input  logic                   clk_cog,
    input  logic                   nres,
    input  logic [SEL_W-1:0]       sel_req,
    input  logic [PINS-1:0]        pin_out,
    input  logic [PINS-1:0]        pin_dir,
    output logic [PINS-1:0]        pin_in,
    input  logic [ROUTES*PINS-1:0] pad_in,
    output logic [ROUTES*PINS-1:0] pad_out,
    output logic [ROUTES*PINS-1:0] pad_oe,
    output logic [SEL_W-1:0]       active_route,
    output logic                   switching
);
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > GUARD_CYCLES) ? DEBOUNCE_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_L = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] GRD_L = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] ONE_L = CNT_W'(1);
    localparam logic [SEL_W:0]   ROUTES_L = (SEL_W + 1)'(ROUTES);
    localparam logic [SEL_W-1:0] RST_L = SEL_W'(RESET_ROUTE);

    typedef enum logic [1:0] {S_CONN, S_QUAL, S_BREAK, S_MAKE} state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       cand_q, cand_d;
    logic [SEL_W-1:0]       active_q, active_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ROUTES*PINS-1:0] pad_oe_q, pad_oe_d;
    logic [ROUTES*PINS-1:0] pad_out_q, pad_out_d;
    logic [PINS-1:0]        hold_q, hold_d;
    logic [SEL_W-1:0]       sel_sync_q [SYNC_STAGES];
    logic [ROUTES*PINS-1:0] pad_sync_q [SYNC_STAGES];
    logic [SEL_W-1:0]       sel_s;
    logic [ROUTES*PINS-1:0] pad_s;
    logic [PINS-1:0]        sel_pad;
    logic                   sel_valid;
    logic                   conn;

    assign sel_s     = sel_sync_q[SYNC_STAGES-1];
    assign pad_s     = pad_sync_q[SYNC_STAGES-1];
    assign sel_valid = {1'b0, sel_s} < ROUTES_L;
    assign conn      = (state_q == S_CONN) || (state_q == S_QUAL);

    // Synchronise the asynchronous selector and pad inputs into clk_cog
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sel_sync_q[i] <= '0;
                pad_sync_q[i] <= '0;
            end
        end else begin
            sel_sync_q[0] <= sel_req;
            pad_sync_q[0] <= pad_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sel_sync_q[i] <= sel_sync_q[i-1];
                pad_sync_q[i] <= pad_sync_q[i-1];
            end
        end
    end

    // Pick the synchronised pad inputs of the currently active route
    always_comb begin
        sel_pad = '0;
        for (int r = 0; r < ROUTES; r++) begin
            if (active_q == SEL_W'(r)) sel_pad = pad_s[r*PINS +: PINS];
        end
    end

    // Next pad drive: only the active route, and only while connected or qualifying
    always_comb begin
        pad_oe_d  = '0;
        pad_out_d = '0;
        for (int r = 0; r < ROUTES; r++) begin
            if (conn && active_q == SEL_W'(r)) begin
                pad_oe_d[r*PINS +: PINS]  = pin_dir;
                pad_out_d[r*PINS +: PINS] = pin_out;
            end
        end
    end

    // Core input view: outputs loop back, inputs come from the pad or the frozen hold value
    always_comb begin
        hold_d = conn ? sel_pad : hold_q;
        pin_in = (pin_dir & pin_out) | (~pin_dir & hold_d);
    end

    // Switchover sequencing: qualify a stable request, release all pads, then reconnect
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        case (state_q)
            S_CONN: begin
                if (sel_valid && sel_s != active_q) begin
                    cand_d  = sel_s;
                    cnt_d   = ONE_L;
                    state_d = S_QUAL;
                end
            end
            S_QUAL: begin
                if (!sel_valid || sel_s == active_q) begin
                    cnt_d   = '0;
                    state_d = S_CONN;
                end else if (sel_s != cand_q) begin
                    cand_d = sel_s;
                    cnt_d  = ONE_L;
                end else if (cnt_q == DEB_L) begin
                    cnt_d   = ONE_L;
                    state_d = S_BREAK;
                end else begin
                    cnt_d = cnt_q + ONE_L;
                end
            end
            S_BREAK: begin
                if (cnt_q == GRD_L) state_d = S_MAKE;
                else cnt_d = cnt_q + ONE_L;
            end
            default: begin
                active_d = cand_q;
                cnt_d    = '0;
                state_d  = S_CONN;
            end
        endcase
    end

    // State, route and registered pad driver flops
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            state_q   <= S_CONN;
            cand_q    <= RST_L;
            active_q  <= RST_L;
            cnt_q     <= '0;
            pad_oe_q  <= '0;
            pad_out_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            pad_oe_q  <= pad_oe_d;
            pad_out_q <= pad_out_d;
            hold_q    <= hold_d;
        end
    end

    assign pad_oe       = pad_oe_q;
    assign pad_out      = pad_out_q;
    assign active_route = active_q;
    assign switching    = (state_q != S_CONN);
endmodule

// File: tb/tb_pin_group_router.sv
// tb_pin_group_router: table vectors, directed switchover sequences and random traffic against a reference model
module tb_pin_group_router;
    localparam int SS  = 2;
    localparam int R   = 2;
    localparam int DEB = 4;
    localparam int GRD = 3;

    logic        clk_cog = 1'b0;
    logic        nres = 1'b0;
    logic [2:0]  sel_req = '0;
    logic [7:0]  pin_out = '0;
    logic [7:0]  pin_dir = '0;
    logic [7:0]  pin_in;
    logic [15:0] pad_in = '0;
    logic [15:0] pad_out;
    logic [15:0] pad_oe;
    logic [2:0]  active_route;
    logic        switching;

    pin_group_router #(
        .PINS(8), .ROUTES(R), .SEL_W(3), .RESET_ROUTE(0),
        .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .GUARD_CYCLES(GRD)
    ) dut (
        .clk_cog(clk_cog), .nres(nres), .sel_req(sel_req),
        .pin_out(pin_out), .pin_dir(pin_dir), .pin_in(pin_in),
        .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe),
        .active_route(active_route), .switching(switching)
    );

    always #5 clk_cog = ~clk_cog;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a dark-cycle countdown and pending-request tracker
    logic [2:0]  m_sel [SS];
    logic [15:0] m_pad [SS];
    logic [7:0]  m_hold;
    logic [15:0] e_oe, e_out;
    int m_active, m_pend, m_age, m_dark;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < SS; k++) begin
            m_sel[k] = '0;
            m_pad[k] = '0;
        end
        m_hold = '0; e_oe = '0; e_out = '0;
        m_active = 0; m_pend = -1; m_age = 0; m_dark = 0;
    endtask

    function automatic logic [7:0] m_route_pad();
        logic [15:0] t;
        t = m_pad[SS-1] >> (8 * m_active);
        return t[7:0];
    endfunction

    task automatic m_step();
        logic [2:0] s;
        s = m_sel[SS-1];
        if (m_dark == 0) begin
            e_oe   = 16'(pin_dir) << (8 * m_active);
            e_out  = 16'(pin_out) << (8 * m_active);
            m_hold = m_route_pad();
        end else begin
            e_oe  = '0;
            e_out = '0;
        end
        if (m_dark > 0) begin
            m_dark--;
            if (m_dark == 0) begin
                m_active = m_pend;
                m_pend   = -1;
            end
        end else if (m_pend >= 0) begin
            if (s >= R || s == m_active) m_pend = -1;
            else if (s != m_pend) begin m_pend = s; m_age = 1; end
            else if (m_age == DEB) m_dark = GRD + 1;
            else m_age++;
        end else if (s < R && s != m_active) begin
            m_pend = s;
            m_age  = 1;
        end
        for (int k = SS - 1; k > 0; k--) begin
            m_sel[k] = m_sel[k-1];
            m_pad[k] = m_pad[k-1];
        end
        m_sel[0] = sel_req;
        m_pad[0] = pad_in;
    endtask

    task automatic cmp_all();
        logic [7:0] src;
        src = (m_dark == 0) ? m_route_pad() : m_hold;
        chk("pad_oe", pad_oe, e_oe);
        chk("pad_out", pad_out, e_out);
        chk("pin_in", pin_in, (pin_dir & pin_out) | (~pin_dir & src));
        chk("active_route", active_route, m_active);
        chk("switching", switching, (m_pend >= 0 || m_dark > 0));
        chk("oe_overlap", (|pad_oe[7:0]) && (|pad_oe[15:8]), 0);
    endtask

    task automatic tick();
        @(posedge clk_cog);
        m_step();
        #1;
        cmp_all();
    endtask

    typedef struct {
        logic [7:0]  dir, out;
        logic [15:0] pad, e_oe, e_out;
        logic [7:0]  e_pin;
    } vec_t;
    vec_t tbl [5];

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int rise, zrun, maxz;
        tbl[0] = '{8'h0F, 8'h05, 16'h12A5, 16'h000F, 16'h0005, 8'hA5};
        tbl[1] = '{8'hFF, 8'h3C, 16'hFF00, 16'h00FF, 16'h003C, 8'h3C};
        tbl[2] = '{8'h00, 8'hFF, 16'h005A, 16'h0000, 16'h00FF, 8'h5A};
        tbl[3] = '{8'hF0, 8'h96, 16'h0033, 16'h00F0, 16'h0096, 8'h93};
        tbl[4] = '{8'h00, 8'h00, 16'hC3A5, 16'h0000, 16'h0000, 8'hA5};

        m_reset();
        pin_dir = 8'h0F;
        pin_out = 8'h05;
        #12;
        cmp_all();
        nres = 1'b1;
        tick();
        chk("rst_rel_oe", pad_oe, 16'h000F);
        chk("rst_rel_out", pad_out, 16'h0005);
        chk("rst_rel_route", active_route, 0);
        chk("rst_rel_sw", switching, 0);

        for (int v = 0; v < 5; v++) begin
            pin_dir = tbl[v].dir;
            pin_out = tbl[v].out;
            pad_in  = tbl[v].pad;
            repeat (3) tick();
            chk("vec_oe", pad_oe, tbl[v].e_oe);
            chk("vec_out", pad_out, tbl[v].e_out);
            chk("vec_pin_in", pin_in, tbl[v].e_pin);
        end

        pin_dir = 8'h0F; pin_out = 8'h05; pad_in = '0;
        sel_req = 3'd1;
        rise = -1; zrun = 0; maxz = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (switching && rise < 0) rise = c;
            zrun = (pad_oe == 0) ? zrun + 1 : 0;
            if (zrun > maxz) maxz = zrun;
        end
        chk("sw_rise_cycle", rise, SS + 1);
        chk("sw_dark_run", maxz, GRD + 1);
        chk("sw_new_oe", pad_oe, 16'h0F00);
        chk("sw_new_route", active_route, 1);

        pin_dir = 8'h00;
        pad_in  = 16'h3CA5;
        repeat (3) tick();
        chk("hold_pre", pin_in, 8'h3C);
        sel_req = 3'd0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk("hold_pin_in", pin_in, (c >= 11) ? 8'hA5 : 8'h3C);
        end
        chk("hold_route", active_route, 0);

        pin_dir = 8'h0F;
        repeat (3) tick();
        sel_req = 3'd1;
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) sel_req = 3'd0;
            tick();
            chk("abort_oe", pad_oe, 16'h000F);
        end
        chk("abort_route", active_route, 0);
        chk("abort_sw", switching, 0);

        sel_req = 3'd3;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk("invalid_sw", switching, 0);
            chk("invalid_oe", pad_oe, 16'h000F);
        end
        sel_req = 3'd0;
        repeat (3) tick();

        sel_req = 3'd1;
        repeat (8) tick();
        chk("pre_rst_dark", pad_oe, 16'h0000);
        chk("pre_rst_sw", switching, 1);
        #1;
        nres = 1'b0;
        m_reset();
        #1;
        chk("mid_rst_oe", pad_oe, 16'h0000);
        chk("mid_rst_route", active_route, 0);
        chk("mid_rst_sw", switching, 0);
        @(posedge clk_cog);
        #1;
        chk("held_rst_oe", pad_oe, 16'h0000);
        nres = 1'b1;
        rise = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 1) chk("post_rst_oe", pad_oe, 16'h000F);
            if (switching && rise < 0) rise = c;
        end
        chk("requal_rise", rise, SS + 1);
        chk("requal_route", active_route, 1);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) sel_req = 3'($urandom_range(0, 3));
            pin_dir = 8'($urandom);
            pin_out = 8'($urandom);
            pad_in  = 16'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pin_group_router.md
Name: pin_group_router

Overview:
- Parametrised successor to the fixed, switch-driven pin multiplexing in the board top levels.
- Routes one group of PINS Propeller pins (pin_out/pin_dir/pin_in) to one of ROUTES physical pad groups, chosen by a raw switch/config selector.
- Switchover is safe and glitch-free: selector synchronisation, stability qualification, and break-before-make with a guard interval in which all pad drivers are released.
- Pad tristate buffers live in the board top level. This block produces only pad_out/pad_oe and consumes pad_in.

Parameters:
- PINS, 8, pins in the group (1..32)
- ROUTES, 2, number of selectable pad groups (2..8)
- SEL_W, 3, selector width; must satisfy 2**SEL_W >= ROUTES
- RESET_ROUTE, 0, route active after reset (< ROUTES)
- SYNC_STAGES, 2, flop stages on sel_req and pad_in (>= 2)
- DEBOUNCE_CYCLES, 1024, cycles sel must be stable before switching (>= 1)
- GUARD_CYCLES, 16, cycles in BREAK state (>= 1)

Ports:
- clk_cog  in  1  core clock; only clock in block
- nres  in  1  reset, active-low, asynchronous
- sel_req  in  SEL_W  requested route (asynchronous, e.g. a board switch)
- pin_out  in  PINS  core pin output values
- pin_dir  in  PINS  core pin directions (1 = output)
- pin_in  out  PINS  core pin input values
- pad_in  in  ROUTES*PINS  pad input values; route r occupies bits [r*PINS +: PINS]
- pad_out  out  ROUTES*PINS  pad drive values, same packing
- pad_oe  out  ROUTES*PINS  pad output enables, same packing
- active_route  out  SEL_W  currently connected route
- switching  out  1  high in QUALIFY, BREAK and MAKE states

Behaviour:
- Reset (nres low, async):
  - state = CONNECTED; active_route = RESET_ROUTE; cand = RESET_ROUTE; cnt = 0.
  - pad_out = 0, pad_oe = 0, switching = 0.
  - All synchroniser flops = 0; pin_in hold register = 0.
- sel_s is sel_req after SYNC_STAGES flops. "Valid" means sel_s < ROUTES.
- pad_s is pad_in after SYNC_STAGES flops.
- Registered pad outputs (1-cycle latency):
  - In CONNECTED or QUALIFY: for route r == active_route, pad_oe = pin_dir and pad_out = pin_out.
  - All other routes, and every route in BREAK or MAKE: pad_oe = 0 and pad_out = 0.
- pin_in, per bit i (combinational):
  - pin_dir[i] = 1: pin_out[i] (loopback, no pad delay).
  - pin_dir[i] = 0 and state is CONNECTED or QUALIFY: pad_s bit i of active_route.
  - pin_dir[i] = 0 and state is BREAK or MAKE: hold register bit i.
  - Hold register samples the selected pad_s every cycle in CONNECTED or QUALIFY, and freezes otherwise.
- FSM:
  - CONNECTED:
    - sel_s valid and != active_route: cand <= sel_s, cnt <= 1, go to QUALIFY.
    - Otherwise stay.
  - QUALIFY:
    - sel_s == active_route or invalid: go to CONNECTED (abort, no pad disturbance).
    - sel_s != cand (and valid): cand <= sel_s, cnt <= 1, stay.
    - cnt == DEBOUNCE_CYCLES: cnt <= 1, go to BREAK.
    - Otherwise cnt++.
  - BREAK:
    - cnt == GUARD_CYCLES: go to MAKE.
    - Otherwise cnt++.
    - sel_s is ignored in this state.
  - MAKE: active_route <= cand, cnt <= 0, go to CONNECTED. A selector change made during BREAK is evaluated from this CONNECTED.
- Guarantees:
  - pad_oe is all-zero for exactly GUARD_CYCLES+1 consecutive cycles across a switch.
  - Old-route and new-route enables are never simultaneously high.
  - A route is never driven while it is not active_route.
- Boundaries:
  - Invalid selector is ignored; no state change from CONNECTED.
  - Counter width is clog2(max(DEBOUNCE_CYCLES, GUARD_CYCLES)+1); no wrap is possible.
  - Reset asserted mid-BREAK returns to RESET_ROUTE immediately, with all pad_oe low until the first clock after release.
  - pin_dir changes in any state take effect on pad_oe one cycle later (CONNECTED/QUALIFY only).

Test Plan:
- Reset release with PINS=8, ROUTES=2, RESET_ROUTE=0, pin_dir=0x0F, pin_out=0x05 → cycle 1 after: pad_oe=0x000F, pad_out=0x0005, active_route=0, switching=0.
- DEBOUNCE_CYCLES=4, GUARD_CYCLES=3, sel_req 0→1 held → switching rises after SYNC_STAGES+1 cycles. pad_oe[7:0] drops to 0, then all pad_oe stay 0 for exactly 4 cycles. Then pad_oe[15:8]=0x0F and active_route=1.
- sel_req 0→1 held 2 cycles then back to 0 (DEBOUNCE_CYCLES=4) → QUALIFY aborts; pad_oe=0x000F never deasserts; active_route stays 0.
- sel_req=3 with ROUTES=2 → no state change; switching stays 0; pad outputs unchanged.
- pin_dir=0x00, pad_in route0=0xA5, then switch to route1 with pad_in route1=0x3C → pin_in=0xA5 (after SYNC_STAGES) and held at 0xA5 through BREAK/MAKE. Becomes 0x3C on first CONNECTED cycle (pad_s already settled).
- nres pulsed low mid-BREAK while switching to route1 → pad_oe=0 and active_route=0 asynchronously. After release, route 0 resumes with sel_req still 1, then a full requalification occurs.
